tlul_adapter_reg_pipe: RTL

- Pipelined TL-UL to register-interface adapter.
- Next generation of the single-outstanding register adapter: supports up to MaxOutstanding in-flight transactions and a configurable register read latency of 0..4 cycles.
- Keeps responses strictly in order through an internal response FIFO.
- Sits between the TL-UL crossbar and a generated reg_top / register file.

---
 rtl/tlul_adapter_reg_pipe.sv | 330 +++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/tlul_adapter_reg_pipe.sv
// Pipelined TL-UL to register-interface adapter.
// Up to MaxOutstanding requests may be in flight; register read data returns
// AccessLatency cycles after the strobe and is queued in an in-order response
// FIFO. Optional macro TLUL_ADAPTER_REG_PIPE_ERR_CNT_EN adds a saturating
// error-response counter (err_cnt_o) with a clear input (err_cnt_clr_i).

package tlul_pkg;

  localparam logic [2:0] PutFullData    = 3'h0;
  localparam logic [2:0] PutPartialData = 3'h1;
  localparam logic [2:0] Get            = 3'h4;
  localparam logic [2:0] AccessAck      = 3'h0;
  localparam logic [2:0] AccessAckData  = 3'h1;

  localparam logic [3:0] MuBi4True  = 4'h6;
  localparam logic [3:0] MuBi4False = 4'h9;

  typedef struct packed {
    logic [3:0] instr_type;
    logic [6:0] cmd_intg;
    logic [6:0] data_intg;
  } tl_a_user_t;

  typedef struct packed {
    logic [6:0] rsp_intg;
    logic [6:0] data_intg;
  } tl_d_user_t;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    tl_a_user_t  a_user;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    tl_d_user_t  d_user;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

  // Returns 1 when the request user bits are malformed (instr_type not a
  // valid multi-bit boolean).
  function automatic logic tl_a_user_chk(tl_a_user_t user);
    return !((user.instr_type == MuBi4True) || (user.instr_type == MuBi4False));
  endfunction

  // Folds a 63-bit vector into a 7-bit parity code.
  function automatic logic [6:0] fold7(logic [62:0] v);
    logic [6:0] r;
    r = '0;
    for (int i = 0; i < 9; i++) r ^= v[i*7 +: 7];
    return r;
  endfunction

endpackage

// Response integrity generator; with both enables cleared the channel passes
// through untouched.
module tlul_rsp_intg_gen
  import tlul_pkg::*;
#(
  parameter bit EnableRspIntgGen  = 1'b1,
  parameter bit EnableDataIntgGen = 1'b1
) (
  input  tl_d2h_t tl_i,
  output tl_d2h_t tl_o
);

  // Overwrite the integrity fields only when generation is enabled.
  always_comb begin
    tl_o = tl_i;
    if (EnableRspIntgGen) begin
      tl_o.d_user.rsp_intg = fold7(63'({tl_i.d_opcode, tl_i.d_size, tl_i.d_source, tl_i.d_error}));
    end
    if (EnableDataIntgGen) begin
      tl_o.d_user.data_intg = fold7(63'(tl_i.d_data));
    end
  end

endmodule

module tlul_adapter_reg_pipe
  import tlul_pkg::*;
#(
  parameter int RegAw          = 8,
  parameter int RegDw          = 32,
  parameter int AccessLatency  = 1,  // 0..4
  parameter int MaxOutstanding = 2   // 1..4, also response FIFO depth
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  tl_h2d_t            tl_i,
  output tl_d2h_t            tl_o,
  output logic               re_o,
  output logic               we_o,
  output logic [RegAw-1:0]   addr_o,
  output logic [RegDw-1:0]   wdata_o,
  output logic [RegDw/8-1:0] be_o,
  input  logic               busy_i,
  input  logic [RegDw-1:0]   rdata_i,
`ifdef TLUL_ADAPTER_REG_PIPE_ERR_CNT_EN
  input  logic               err_cnt_clr_i,
  output logic [7:0]         err_cnt_o,
`endif
  input  logic               error_i
);

  localparam int CntW = 4;
  localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

  typedef struct packed {
    logic       valid;
    logic [7:0] source;
    logic [1:0] size;
    logic       is_read;
    logic       err_int;
  } tag_t;

  typedef struct packed {
    logic [2:0]       opcode;
    logic [7:0]       source;
    logic [1:0]       size;
    logic [RegDw-1:0] data;
    logic             err;
  } rsp_t;

  logic            rst_d, rst_q;
  logic            in_block;
  logic            is_get, is_put, err_int;
  logic            a_ready, a_ack;
  logic [CntW-1:0] pipe_used, used;
  tag_t            in_tag, exit_tag;

  logic            push, pop, fifo_full, d_valid;
  rsp_t            push_rsp, head_rsp;
  rsp_t            fifo_mem_q [MaxOutstanding];
  rsp_t            fifo_mem_d [MaxOutstanding];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] fifo_cnt_q, fifo_cnt_d;
  tl_d2h_t         tl_o_pre;

  function automatic logic [PtrW-1:0] ptr_inc(logic [PtrW-1:0] p);
    return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + 1'b1;
  endfunction

  // Remember that reset was asserted last cycle so no request is accepted
  // in the first cycle after release.
  assign rst_d = rst_i;
  // NOTE: sequential state is always assigned with <=, so every flop samples
  // the pre-edge value of its _d signal regardless of block order.
  always_ff @(posedge clk_i) begin
    rst_q <= rst_d;
  end
  assign in_block = rst_i | rst_q;

  // Decode the request, check legality, and form the credit-gated handshake.
  always_comb begin
    is_get  = (tl_i.a_opcode == Get);
    is_put  = (tl_i.a_opcode == PutFullData) || (tl_i.a_opcode == PutPartialData);
    err_int = !(is_get || is_put)
            || (is_put && (tl_i.a_address[1:0] != 2'b00))
            || (tl_i.a_size > 2'd2)
            || tl_a_user_chk(tl_i.a_user);
    used    = pipe_used + fifo_cnt_q;
    a_ready = (in_block || (used < CntW'(MaxOutstanding)))
            && !(tl_i.a_valid && (busy_i || in_block));
    a_ack   = tl_i.a_valid && a_ready;
    in_tag  = '{valid:   a_ack,
                source:  tl_i.a_source,
                size:    tl_i.a_size,
                is_read: is_get,
                err_int: err_int};
  end

  assign re_o    = a_ack && is_get && !err_int;
  assign we_o    = a_ack && is_put && !err_int;
  assign wdata_o = tl_i.a_data;
  assign be_o    = tl_i.a_mask;

  if (RegAw > 2) begin : g_addr
    assign addr_o = {tl_i.a_address[RegAw-1:2], 2'b00};
  end else begin : g_addr_zero
    assign addr_o = '0;
  end

  if (AccessLatency == 0) begin : g_no_pipe
    assign exit_tag  = in_tag;
    assign pipe_used = '0;
  end else begin : g_pipe
    tag_t pipe_q [AccessLatency];
    tag_t pipe_d [AccessLatency];

    // Shift the request tags along so each one exits alongside its read data.
    always_comb begin
      pipe_d[0] = in_tag;
      for (int i = 1; i < AccessLatency; i++) pipe_d[i] = pipe_q[i-1];
    end

    // Tag pipeline registers; a reset drops every in-flight request.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        for (int i = 0; i < AccessLatency; i++) pipe_q[i] <= '0;
      end else begin
        pipe_q <= pipe_d;
      end
    end

    // Count occupied stages as consumed credits.
    always_comb begin
      pipe_used = '0;
      for (int i = 0; i < AccessLatency; i++) pipe_used += CntW'(pipe_q[i].valid);
    end

    assign exit_tag = pipe_q[AccessLatency-1];
  end

  // Build the response for the tag leaving the pipeline this cycle.
  always_comb begin
    push              = exit_tag.valid;
    push_rsp.opcode   = exit_tag.is_read ? AccessAckData : AccessAck;
    push_rsp.source   = exit_tag.source;
    push_rsp.size     = exit_tag.size;
    push_rsp.err      = exit_tag.err_int || error_i;
    push_rsp.data     = (error_i || exit_tag.err_int || !exit_tag.is_read) ? '1 : rdata_i;
  end

  assign fifo_full = (fifo_cnt_q == CntW'(MaxOutstanding));
  assign d_valid   = (fifo_cnt_q != '0) && !rst_i;
  assign pop       = d_valid && tl_i.d_ready;
  assign head_rsp  = fifo_mem_q[rd_ptr_q];

  // Response FIFO next-state: write at wr_ptr on push, advance rd_ptr on pop.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    fifo_mem_d = fifo_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (push) begin
      fifo_mem_d[wr_ptr_q] = push_rsp;
      wr_ptr_d             = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    fifo_cnt_d = fifo_cnt_q + CntW'(push) - CntW'(pop);
  end

  // FIFO control registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  // FIFO storage.
  // NOTE: storage is not reset; the reset count and pointers already mark
  // every entry invalid, and the unread head is never exposed as valid.
  always_ff @(posedge clk_i) begin
    fifo_mem_q <= fifo_mem_d;
  end

  overflow_a: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push && fifo_full && !pop));

  // Drive the response channel from the FIFO head.
  always_comb begin
    tl_o_pre          = '0;
    tl_o_pre.d_valid  = d_valid;
    tl_o_pre.d_opcode = head_rsp.opcode;
    tl_o_pre.d_size   = head_rsp.size;
    tl_o_pre.d_source = head_rsp.source;
    tl_o_pre.d_data   = head_rsp.data;
    tl_o_pre.d_error  = d_valid && head_rsp.err;
    tl_o_pre.a_ready  = a_ready;
  end

  tlul_rsp_intg_gen #(
    .EnableRspIntgGen  (1'b0),
    .EnableDataIntgGen (1'b0)
  ) u_rsp_intg (
    .tl_i (tl_o_pre),
    .tl_o (tl_o)
  );

`ifdef TLUL_ADAPTER_REG_PIPE_ERR_CNT_EN
  logic [7:0] err_cnt_d, err_cnt_q;

  // Saturating count of error responses; clear wins over increment.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_cnt_clr_i) begin
      err_cnt_d = '0;
    end else if (push && push_rsp.err && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  // Error counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) err_cnt_q <= '0;
    else       err_cnt_q <= err_cnt_d;
  end

  assign err_cnt_o = err_cnt_q;
`endif

  logic unused_tl;
  assign unused_tl = ^{tl_i.a_param, tl_i.a_user.cmd_intg, tl_i.a_user.data_intg,
                       tl_i.a_address};

endmodule
